// File: rtl/ascon_perm_iter_pkg.sv
// Shared types and constants for the iterative Ascon permutation.
// FSM encoding, S-box table, linear-layer rotations and the round-constant rule.
package ascon_perm_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    localparam int ROUNDS_MAX = 12;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    // Rotation pairs per lane, index 0 = x0 ... 4 = x4
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return {4'hF - idx, idx};
    endfunction

endpackage

// File: rtl/ascon_perm_iter_perm_l.sv
// Ascon linear diffusion layer: each lane xk ^= ROR(xk,a) ^ ROR(xk,b).
// Purely combinational, zero latency.
// No flow control; output follows input.
module perm_l
    import ascon_perm_iter_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [5*W-1:0] state_in,
    output logic [5*W-1:0] state_out
);

    for (genvar k = 0; k < 5; k++) begin : g_lane
        localparam int RA = ROT_A[k];
        localparam int RB = ROT_B[k];
        logic [W-1:0] lane;
        assign lane = state_in[(4-k)*W +: W];
        assign state_out[(4-k)*W +: W] = lane
            ^ ((lane >> RA) | (lane << (W - RA)))
            ^ ((lane >> RB) | (lane << (W - RB)));
    end

endmodule

// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation, one round per cycle (constant add, S-box, linear layer).
// Latency: r cycles from acceptance to out_valid; r = 12 when rounds is 0 or above 12.
// Backpressure: result held in DONE until out_ready; one request per r+2 cycles.
module ascon_perm_iter
    import ascon_perm_iter_pkg::*;
#(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [5*W-1:0] state_in,
    input  logic [3:0]     rounds,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [5*W-1:0] state_out
);

    fsm_t           fsm_q;
    logic [5*W-1:0] state_q;
    logic [3:0]     idx_q;
    logic [3:0]     r_eff;
    logic [5*W-1:0] ca_state;
    logic [5*W-1:0] sb_state;
    logic [5*W-1:0] round_state;

    assign r_eff = (rounds == 4'd0 || rounds > 4'(ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : rounds;

    always_comb begin
        ca_state = state_q;
        ca_state[2*W +: 8] = state_q[2*W +: 8] ^ round_const(idx_q);
    end

    // Bit column j gathers bit j of every lane, x0 as the MSB of the S-box index
    for (genvar j = 0; j < W; j++) begin : g_col
        logic [4:0] col;
        logic [4:0] sb;
        assign col = {ca_state[4*W+j], ca_state[3*W+j], ca_state[2*W+j],
                      ca_state[W+j], ca_state[j]};
        assign sb  = SBOX[col];
        assign sb_state[4*W+j] = sb[4];
        assign sb_state[3*W+j] = sb[3];
        assign sb_state[2*W+j] = sb[2];
        assign sb_state[W+j]   = sb[1];
        assign sb_state[j]     = sb[0];
    end

    perm_l #(.W(W)) u_perm_l (
        .state_in  (sb_state),
        .state_out (round_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            state_q   <= '0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_ready && in_valid) begin
                        state_q  <= state_in;
                        idx_q    <= 4'(ROUNDS_MAX) - r_eff;
                        in_ready <= 1'b0;
                        fsm_q    <= RUN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= round_state;
                    idx_q   <= idx_q + 4'd1;
                    if (idx_q == 4'(ROUNDS_MAX - 1)) begin
                        out_valid <= 1'b1;
                        fsm_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    fsm_q     <= IDLE;
                end
            endcase
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Randomized bench for ascon_perm_iter against a bitsliced reference of the Ascon permutation.
module tb_ascon_perm_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [319:0] state_in;
    logic [3:0]   rounds;
    logic         out_valid;
    logic         out_ready;
    logic [319:0] state_out;

    int n_checks = 0;
    int n_fail   = 0;

    ascon_perm_iter #(.W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .rounds    (rounds),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ror(input logic [63:0] v, input int a);
        return (v >> a) | (v << (64 - a));
    endfunction

    // Reference: Ascon round written in the bitsliced boolean form of the C implementation
    function automatic logic [319:0] ascon_ref(input logic [319:0] s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        for (int i = 12 - r; i < 12; i++) begin
            x2 ^= 64'(((15 - i) << 4) | i);
            x0 ^= x4; x4 ^= x3; x2 ^= x1;
            t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
            x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
            x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
            x0 ^= ror(x0, 19) ^ ror(x0, 28);
            x1 ^= ror(x1, 61) ^ ror(x1, 39);
            x2 ^= ror(x2, 1)  ^ ror(x2, 6);
            x3 ^= ror(x3, 10) ^ ror(x3, 17);
            x4 ^= ror(x4, 7)  ^ ror(x4, 41);
        end
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic int eff_rounds(input logic [3:0] r);
        return (r == 4'd0 || r > 4'd12) ? 12 : int'(r);
    endfunction

    function automatic logic [319:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_perm(input logic [319:0] s, input logic [3:0] r, input int hold,
                           output logic [319:0] res);
        int n;
        int lat;
        logic [319:0] exp;
        logic [319:0] snap;
        lat = eff_rounds(r);
        exp = ascon_ref(s, lat);
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check_eq("in_ready_wait", in_ready, 1);
        state_in = s; rounds = r; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
        check_eq($sformatf("latency_r%0d", r), n, lat);
        check_eq($sformatf("result_r%0d", r), state_out, exp);
        snap = state_out;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check_eq("hold_out_valid", out_valid, 1);
            check_eq("hold_state", state_out, snap);
            check_eq("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        check_eq("done_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("release_out_valid", out_valid, 0);
        check_eq("release_in_ready", in_ready, 1);
        res = snap;
    endtask

    task automatic back_to_back(input logic [3:0] r);
        logic [319:0] q[$];
        logic [319:0] exp;
        logic         pend;
        int acc = 0;
        int got = 0;
        int cyc = 0;
        int last_acc = -1;
        int lat;
        lat = eff_rounds(r);
        state_in = rand_state(); rounds = r; in_valid = 1'b1; out_ready = 1'b1;
        while (got < 5 && cyc < 300) begin
            pend = in_valid && in_ready;
            if (out_valid) begin
                check_eq("b2b_inflight", q.size(), 1);
                if (q.size() > 0) begin
                    exp = q.pop_front();
                    check_eq("b2b_result", state_out, exp);
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (pend) begin
                q.push_back(ascon_ref(state_in, lat));
                if (last_acc >= 0) check_eq("b2b_spacing", cyc - last_acc, lat + 2);
                last_acc = cyc;
                acc++;
                state_in = rand_state();
                if (acc == 5) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("b2b_accepts", acc, 5);
        check_eq("b2b_outputs", got, 5);
        check_eq("b2b_leftover", q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [319:0] s;
        logic [319:0] res;
        logic [319:0] res12;
        logic         saw_ov;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; state_in = '0; rounds = '0;
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_state", state_out, 0);
        rst_n = 1'b1;
        check_eq("rst_rel_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        check_eq("rst_rel_in_ready", in_ready, 1);

        do_perm('0, 4'd1, 0, res);
        check_eq("r1_x4", res[63:0], 0);

        s = rand_state();
        do_perm(s, 4'd12, 0, res12);
        do_perm(s, 4'd0, 0, res);
        check_eq("r0_vs_r12", res, res12);
        do_perm(s, 4'd15, 0, res);
        check_eq("r15_vs_r12", res, res12);
        do_perm(rand_state(), 4'd6, 0, res);
        do_perm(rand_state(), 4'd12, 5, res);

        for (int t = 0; t < 6; t++) begin
            do_perm(rand_state(), 4'($urandom_range(0, 15)), $urandom_range(0, 3), res);
        end

        // Abandon a 12-round permutation during its fourth round
        state_in = rand_state(); rounds = 4'd12; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_in_ready", in_ready, 0);
        check_eq("midrst_state", state_out, 0);
        saw_ov = 1'b0;
        repeat (14) begin @(posedge clk); #1; saw_ov |= out_valid; end
        check_eq("midrst_no_pulse", saw_ov, 0);
        rst_n = 1'b1;
        saw_ov = 1'b0;
        repeat (14) begin @(posedge clk); #1; saw_ov |= out_valid; end
        check_eq("midrst_no_late_pulse", saw_ov, 0);
        check_eq("midrst_in_ready_back", in_ready, 1);
        do_perm(rand_state(), 4'd12, 0, res);

        back_to_back(4'd2);
        back_to_back(4'd5);
        back_to_back(4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
